// File: rtl/placement_pkg.sv
// placement_pkg: constants and FSM encoding shared by the placer and the cost evaluator.
package placement_pkg;
   localparam int N_DEF      = 7;
   localparam int N_EDGE_DEF = 52;
   localparam int W_DEF      = 32;
   localparam int POS_DEPTH  = N_DEF * N_DEF;
   localparam int EDGE_DEPTH = N_EDGE_DEF;
   localparam int UNPLACED   = -1;
   typedef enum logic [3:0] {
      IDLE, RD_E, W_E, LAT_E, RD_A, W_A, LAT_A, RD_B, W_B, LAT_B, CHK, ACC, FIN
   } state_t;
endpackage

// File: rtl/edge_cost_calc.sv
// edge_cost_calc: per-edge Manhattan and ceil-halved lengths plus grid legality check.
module edge_cost_calc
   import placement_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int N = N_DEF
) (
   input  logic signed [W-1:0] xa,
   input  logic signed [W-1:0] ya,
   input  logic signed [W-1:0] xb,
   input  logic signed [W-1:0] yb,
   output logic signed [W-1:0] len,
   output logic signed [W-1:0] hop_len,
   output logic                illegal
);
   localparam logic signed [W-1:0] LIM = W'(N);
   logic signed [W-1:0] dx, dy;
   function automatic logic bad(input logic signed [W-1:0] v);
      return v[W-1] || v >= LIM;
   endfunction
   always_comb begin
      dx      = xa > xb ? xa - xb : xb - xa;
      dy      = ya > yb ? ya - yb : yb - ya;
      len     = dx + dy;
      hop_len = (dx >>> 1) + (dy >>> 1) + W'(dx[0]) + W'(dy[0]);
      illegal = bad(xa) || bad(ya) || bad(xb) || bad(yb);
   end
endmodule

// File: rtl/placement_cost_eval.sv
// placement_cost_eval: walks the edge ROMs, fetches endpoint positions and accumulates wirelength costs.
module placement_cost_eval
   import placement_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int N_EDGE = N_EDGE_DEF,
   parameter int RD_LAT = 1,
   parameter int W      = W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [W-1:0]        err_edge,
   output logic signed [W-1:0] sum,
   output logic signed [W-1:0] sum_1hop,
   output logic signed [W-1:0] max_len,
   output logic                reE,
   output logic [W-1:0]        addrE,
   input  logic [W-1:0]        edgeA,
   input  logic [W-1:0]        edgeB,
   output logic                reP,
   output logic [W-1:0]        addrP,
   input  logic signed [W-1:0] posX,
   input  logic signed [W-1:0] posY
);
   state_t state;
   logic [W-1:0] i, ra, rb, nxt;
   logic [7:0] wc;
   logic signed [W-1:0] xa, ya, xb, yb, len, hop_len, len_q, hop_q;
   logic illegal, last;

   edge_cost_calc #(.W(W), .N(N)) u_calc (
      .xa(xa), .ya(ya), .xb(xb), .yb(yb),
      .len(len), .hop_len(hop_len), .illegal(illegal)
   );

   assign nxt  = state == ACC ? i + W'(1) : i;
   assign last = nxt == W'(N_EDGE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         reE      <= 1'b0;
         reP      <= 1'b0;
         sum      <= '0;
         sum_1hop <= '0;
         max_len  <= '0;
         err_edge <= '0;
         addrE    <= '0;
         addrP    <= '0;
         i        <= '0;
         wc       <= '0;
      end else begin
         reE  <= 1'b0;
         reP  <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               sum      <= '0;
               sum_1hop <= '0;
               max_len  <= '0;
               err      <= 1'b0;
               i        <= '0;
               busy     <= 1'b1;
               state    <= RD_E;
            end
            // ACC folds in the next edge-fetch decision, keeping each edge at 10 cycles.
            RD_E, ACC: begin
               if (state == ACC) begin
                  sum      <= sum + len_q - W'(1);
                  sum_1hop <= sum_1hop + hop_q - W'(1);
                  max_len  <= len_q > max_len ? len_q : max_len;
                  i        <= nxt;
               end
               if (last) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FIN;
               end else begin
                  reE   <= 1'b1;
                  addrE <= nxt;
                  wc    <= 8'(RD_LAT - 1);
                  state <= W_E;
               end
            end
            W_E, W_A, W_B: begin
               if (wc != 8'd0) wc <= wc - 8'd1;
               else state <= state == W_E ? LAT_E : state == W_A ? LAT_A : LAT_B;
            end
            LAT_E: begin
               ra    <= edgeA;
               rb    <= edgeB;
               state <= RD_A;
            end
            RD_A: begin
               reP   <= 1'b1;
               addrP <= ra;
               wc    <= 8'(RD_LAT - 1);
               state <= W_A;
            end
            LAT_A: begin
               xa    <= posX;
               ya    <= posY;
               state <= RD_B;
            end
            RD_B: begin
               reP   <= 1'b1;
               addrP <= rb;
               wc    <= 8'(RD_LAT - 1);
               state <= W_B;
            end
            LAT_B: begin
               xb    <= posX;
               yb    <= posY;
               state <= CHK;
            end
            CHK: if (illegal) begin
               err      <= 1'b1;
               err_edge <= i;
               busy     <= 1'b0;
               done     <= 1'b1;
               state    <= FIN;
            end else begin
               len_q <= len;
               hop_q <= hop_len;
               state <= ACC;
            end
            FIN: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_placement_cost_eval.sv
// tb_placement_cost_eval: directed and randomized checks of the cost evaluator against a wirelength model.
module tb_placement_cost_eval;
   localparam int ND = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [ND-1:0] start = '0;
   logic [ND-1:0] busy, done, err, reE, reP;
   logic [ND-1:0][31:0] err_edge, sum, sum_1hop, max_len, addrE, addrP;
   int ea[64], eb[64], px[64], py[64];
   int checks = 0, errors = 0;
   int exp_sum, exp_hop, exp_max, exp_edge, exp_lat;
   bit exp_err;

   always #5 clk = ~clk;

   // instances with N_EDGE = 52, 1, 2, 0 share the memory contents
   for (genvar g = 0; g < ND; g++) begin : g_dut
      logic [31:0] qa, qb, qx, qy;
      always @(posedge clk) begin
         if (reE[g]) begin
            qa <= ea[addrE[g][5:0]];
            qb <= eb[addrE[g][5:0]];
         end
         if (reP[g]) begin
            qx <= px[addrP[g][5:0]];
            qy <= py[addrP[g][5:0]];
         end
      end
      placement_cost_eval #(.N_EDGE(g == 0 ? 52 : g == 1 ? 1 : g == 2 ? 2 : 0)) u_dut (
         .clk(clk), .reset(reset), .start(start[g]), .busy(busy[g]), .done(done[g]),
         .err(err[g]), .err_edge(err_edge[g]), .sum(sum[g]), .sum_1hop(sum_1hop[g]),
         .max_len(max_len[g]), .reE(reE[g]), .addrE(addrE[g]), .edgeA(qa), .edgeB(qb),
         .reP(reP[g]), .addrP(addrP[g]), .posX(qx), .posY(qy)
      );
   end

   task automatic chk(input string tag, input longint got, input longint want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, got, want);
      end
   endtask

   function automatic bit on_grid(input int v);
      return v >= 0 && v < 7;
   endfunction

   task automatic model(input int ne);
      exp_sum = 0; exp_hop = 0; exp_max = 0; exp_err = 0; exp_edge = 0;
      exp_lat = 10 * ne + 2;
      for (int k = 0; k < ne; k++) begin
         int xa, ya, xb, yb, dx, dy;
         xa = px[ea[k]]; ya = py[ea[k]];
         xb = px[eb[k]]; yb = py[eb[k]];
         if (!(on_grid(xa) && on_grid(ya) && on_grid(xb) && on_grid(yb))) begin
            exp_err = 1; exp_edge = k; exp_lat = 10 * k + 11;
            return;
         end
         dx = xa > xb ? xa - xb : xb - xa;
         dy = ya > yb ? ya - yb : yb - ya;
         exp_sum += dx + dy - 1;
         exp_hop += (dx + 1) / 2 + (dy + 1) / 2 - 1;
         if (dx + dy > exp_max) exp_max = dx + dy;
      end
   endtask

   task automatic run(input int g, input int ne, input bit poke);
      int n;
      model(ne);
      @(negedge clk); start[g] = 1'b1;
      @(negedge clk); start[g] = 1'b0; n = 1;
      chk("busy_after_start", busy[g], 1);
      while (!done[g] && n < 2000) begin
         start[g] = poke && n == 4;
         @(negedge clk); n++;
      end
      start[g] = 1'b0;
      chk("done_seen", done[g], 1);
      chk("latency", n, exp_lat);
      chk("busy_at_done", busy[g], 0);
      start[g] = 1'b1;
      @(negedge clk); start[g] = 1'b0;
      chk("done_one_cycle", done[g], 0);
      chk("fin_start_ignored", busy[g], 0);
      chk("err", err[g], exp_err);
      if (exp_err) chk("err_edge", err_edge[g], exp_edge);
      chk("sum", $signed(sum[g]), exp_sum);
      chk("sum_1hop", $signed(sum_1hop[g]), exp_hop);
      chk("max_len", $signed(max_len[g]), exp_max);
   endtask

   task automatic randomize_mem(input bit inject);
      for (int k = 0; k < 64; k++) begin
         ea[k] = $urandom_range(0, 48);
         eb[k] = $urandom_range(0, 48);
         px[k] = $urandom_range(0, 6);
         py[k] = $urandom_range(0, 6);
      end
      if (inject) px[ea[$urandom_range(0, 51)]] = ($urandom_range(0, 1) != 0) ? -1 : 7 + int'($urandom_range(0, 2));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", busy[0], 0);
      chk("rst_done", done[0], 0);
      chk("rst_err", err[0], 0);
      chk("rst_reE", reE[0], 0);
      chk("rst_reP", reP[0], 0);
      chk("rst_sum", sum[0], 0);
      chk("rst_max", max_len[0], 0);
      chk("rst_addrE", addrE[0], 0);
      reset = 1'b0;
      ea[0] = 0; eb[0] = 1; px[0] = 0; py[0] = 0; px[1] = 3; py[1] = 4;
      run(1, 1, 0);
      ea[1] = 1; eb[1] = 2; px[1] = 0; py[1] = 1; px[2] = 1; py[2] = 1;
      run(2, 2, 0);
      px[0] = 2; py[0] = 2; px[1] = 2; py[1] = 2;
      run(1, 1, 0);
      run(3, 0, 0);
      px[0] = 0; py[0] = 0; px[1] = 3; py[1] = 4; px[2] = -1; py[2] = -1;
      run(2, 2, 0);
      px[0] = 7;
      run(1, 1, 1);
      for (int r = 0; r < 4; r++) begin
         randomize_mem(r == 3);
         run(0, 52, r[0]);
      end
      randomize_mem(0);
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      repeat (205) @(negedge clk);
      chk("pre_reset_busy", busy[0], 1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", busy[0], 0);
      chk("mid_rst_sum", sum[0], 0);
      chk("mid_rst_hop", sum_1hop[0], 0);
      chk("mid_rst_max", max_len[0], 0);
      chk("mid_rst_addrE", addrE[0], 0);
      chk("mid_rst_addrP", addrP[0], 0);
      reset = 1'b0;
      run(0, 52, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/placement_cost_eval.md
Name: placement_cost_eval

Overview:
- Standalone cost evaluator downstream of the random placer.
- After the placer has written the pos_X/pos_Y RAMs, this block walks the edge list in the edge-A/edge-B ROMs. For each edge it fetches both endpoint coordinates and accumulates Manhattan wirelength and 1-hop (ceil-halved) wirelength.
- It also tracks the longest edge and flags unplaced or out-of-grid nodes.
- Start/done handshake lets the placer, or a future multi-try controller, launch it and compare costs between placements.

Parameters:
- N, 7: grid side; legal coordinate range is 0..N-1.
- N_EDGE, 52: number of edges to evaluate (edge addresses 0..N_EDGE-1).
- RD_LAT, 1: cycles from a sampled read enable to valid memory dout; the same for the ROMs and the position RAMs.
- W, 32: data/accumulator width, signed.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle launch pulse; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the result registers are final.
- err  out  1  sticky until next start; an illegal coordinate was seen.
- err_edge  out  W  index of the first offending edge.
- sum  out  W  signed total of (dx+dy-1) over all edges.
- sum_1hop  out  W  signed total of (ceil(dx/2)+ceil(dy/2)-1).
- max_len  out  W  maximum dx+dy over all edges.
- reE  out  1  read enable to both edge ROMs.
- addrE  out  W  edge index driven to both ROMs.
- edgeA  in  W  dout of edge-A ROM.
- edgeB  in  W  dout of edge-B ROM.
- reP  out  1  read enable to both position RAMs.
- addrP  out  W  node id driven to both RAMs.
- posX  in  W  dout of pos_X RAM.
- posY  in  W  dout of pos_Y RAM.

Behaviour:
- Reset, and any cycle with reset high including mid-walk:
  - state=IDLE.
  - busy, done, err, reE and reP all 0.
  - sum, sum_1hop, max_len, err_edge, addrE and addrP all 0.
  - Edge counter i=0.
- reE and reP are single-cycle pulses, default 0 every cycle.
- FSM states:
  - IDLE: on start, clear sum, sum_1hop, max_len and err; set i=0 and busy=1; go to RD_E.
  - RD_E: if i==N_EDGE go to FIN. Otherwise drive reE=1, addrE=i, then wait RD_LAT cycles and go to LAT_E.
  - LAT_E: latch edgeA into ra and edgeB into rb.
  - RD_A: drive reP=1, addrP=ra, wait RD_LAT, go to LAT_A.
  - LAT_A: latch xa=posX, ya=posY.
  - RD_B: drive reP=1, addrP=rb, wait RD_LAT, go to LAT_B.
  - LAT_B: latch xb, yb.
  - CHK: if any of xa, ya, xb, yb is <0 or >=N, set err=1 and err_edge=i, then go to FIN (abort; partial sums are held). Otherwise compute dx=|xa-xb| and dy=|ya-yb| as signed W-bit values and go to ACC.
  - ACC: add to the accumulators, as follows.
    - sum += dx+dy-1.
    - sum_1hop += (dx>>1)+dx[0]+(dy>>1)+dy[0]-1.
    - max_len = max(max_len, dx+dy).
    - i++; return to RD_E.
  - FIN: busy=0, done=1 for exactly one cycle; go to IDLE.
- Result outputs are stable from done until the next accepted start.
- Latency for an error-free walk with RD_LAT=1 is 10 cycles per edge plus 2 cycles (start to done). The bench checks this exact count.
- start while busy is ignored.
- start in the FIN cycle is ignored; start in the cycle after done is accepted.
- N_EDGE=0 gives done 2 cycles after start with all results 0.
- Accumulator overflow wraps modulo 2^W with no flag.
- A coincident edge (dx=dy=0) contributes -1 to both sums; this is legal, not an error.
- A coordinate of -1 (unplaced marker in pos RAM init) triggers err.

Decomposition:
- Shared package placement_pkg holds:
  - state encodings.
  - UNPLACED=-1.
  - Defaults N=7, N_EDGE=52, W=32.
  - The memory-depth constants shared with the placer.
- Natural sub-module: edge_cost_calc, a combinational/registered datapath. It takes xa, ya, xb, yb and N and produces dx, dy, len, hop_len and illegal. The FSM stays in the top.

Test Plan:
- N_EDGE=1, edge (0,1), node0 at (0,0), node1 at (3,4): sum=6, sum_1hop=3, max_len=7, err=0, done exactly 12 cycles after start.
- N_EDGE=2, edges (0,1),(1,2), nodes at (0,0),(0,1),(1,1): sum=0, sum_1hop=0, max_len=1.
- Coincident nodes at (2,2),(2,2) with N_EDGE=1: sum=-1, sum_1hop=-1, max_len=0, err=0.
- Second edge endpoint at (-1,-1): err=1, err_edge=1, sum equals the first edge only, done pulses.
- Out-of-grid coordinate x=7 with N=7: err=1. Also a start pulse during busy: ignored, with no restart and sums unchanged.
- Reset asserted mid-walk at edge 20: all outputs 0 next cycle. A fresh start then produces a result identical to an uninterrupted run, and the full 52-edge run matches a software model.
